// File: rtl/control_sequencer_if.sv
// control_sequencer_if: instruction-side inputs and decoded control/sequencing outputs of control_sequencer.
interface control_sequencer_if;
    logic [6:0] opcode;
    logic       instr_valid;
    logic       bus_ready;
    logic       irq;
    logic [2:0] cs_imm_src;
    logic       cs_reg_write;
    logic       cs_reg_1_zero;
    logic       cs_alu_src;
    logic [1:0] cs_alu_control;
    logic [1:0] cs_mem_to_reg;
    logic [1:0] cs_branch_op;
    logic       cs_bus_read;
    logic       cs_bus_write;
    logic       cs_end_isr;
    logic       stall;
    logic       isr_enter;
    logic       in_isr;
    logic       illegal;
    logic       bus_error;

    modport master (
        output opcode, instr_valid, bus_ready, irq,
        input  cs_imm_src, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_control, cs_mem_to_reg,
               cs_branch_op, cs_bus_read, cs_bus_write, cs_end_isr, stall, isr_enter, in_isr,
               illegal, bus_error
    );
    modport slave (
        input  opcode, instr_valid, bus_ready, irq,
        output cs_imm_src, cs_reg_write, cs_reg_1_zero, cs_alu_src, cs_alu_control, cs_mem_to_reg,
               cs_branch_op, cs_bus_read, cs_bus_write, cs_end_isr, stall, isr_enter, in_isr,
               illegal, bus_error
    );
endinterface

// File: rtl/control_sequencer.sv
// control_sequencer: RV32 opcode decode plus stall sequencing for data-bus waits, IRQ entry and ISR return.
module control_sequencer #(
    parameter int LOAD_WAIT  = 1,
    parameter int STORE_WAIT = 0,
    parameter int HANDSHAKE  = 0,
    parameter int TIMEOUT    = 15
) (
    input logic clk,
    input logic reset,
    control_sequencer_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, IRQ_ENTRY} state_t;
    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_RETI = 7'b1111111;
    state_t state, state_next;
    logic [7:0] cnt, cnt_next, wait_n;
    logic [14:0] dec;
    logic known, gate, mem, stall_c, timeout, in_isr_q;

    always_comb begin
        dec = '0;
        known = 1'b1;
        case (bus.opcode)
            7'b0110011: dec = 15'b000_1_0_0_11_00_00_0_0_0;
            7'b0010011: dec = 15'b001_1_0_1_10_00_00_0_0_0;
            7'b1100011: dec = 15'b011_0_0_0_01_00_01_0_0_0;
            7'b1101111: dec = 15'b100_1_1_1_00_10_10_0_0_0;
            7'b1100111: dec = 15'b001_1_0_1_00_10_11_0_0_0;
            OP_LOAD:    dec = 15'b001_1_0_1_00_01_00_1_0_0;
            OP_STORE:   dec = 15'b010_0_0_1_00_00_00_0_1_0;
            7'b0110111: dec = 15'b000_1_1_1_00_00_00_0_0_0;
            OP_RETI:    dec = 15'b000_0_0_0_00_00_00_0_0_1;
            default:    known = 1'b0;
        endcase
    end

    assign gate = !reset && bus.instr_valid && state != IRQ_ENTRY;
    assign mem = gate && (bus.opcode == OP_LOAD || bus.opcode == OP_STORE);
    assign wait_n = bus.opcode == OP_LOAD ? 8'(LOAD_WAIT) : 8'(STORE_WAIT);

    // cnt counts down the fixed wait, or counts up stalled cycles toward TIMEOUT in handshake mode
    always_comb begin
        state_next = state;
        cnt_next = cnt;
        stall_c = 1'b0;
        timeout = 1'b0;
        case (state)
            RUN: begin
                if (mem && HANDSHAKE != 0) begin
                    stall_c = !bus.bus_ready;
                    cnt_next = 8'd1;
                end else if (mem) begin
                    stall_c = wait_n != 8'd0;
                    cnt_next = wait_n;
                end
                if (stall_c) state_next = MEM_WAIT;
                else if (gate && bus.irq && !in_isr_q) state_next = IRQ_ENTRY;
            end
            MEM_WAIT: begin
                if (HANDSHAKE != 0) begin
                    timeout = !bus.bus_ready && cnt >= 8'(TIMEOUT);
                    stall_c = !bus.bus_ready && !timeout;
                    cnt_next = cnt + 8'd1;
                end else begin
                    stall_c = cnt > 8'd1;
                    cnt_next = cnt - 8'd1;
                end
                if (!stall_c) state_next = RUN;
            end
            default: begin
                stall_c = 1'b1;
                state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt <= '0;
            in_isr_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt <= cnt_next;
            in_isr_q <= state == IRQ_ENTRY ? 1'b1 : bus.cs_end_isr ? 1'b0 : in_isr_q;
        end
    end

    assign bus.cs_imm_src = dec[14:12];
    assign bus.cs_reg_write = dec[11] && gate && !stall_c && !timeout;
    assign bus.cs_reg_1_zero = dec[10];
    assign bus.cs_alu_src = dec[9];
    assign bus.cs_alu_control = dec[8:7];
    assign bus.cs_mem_to_reg = dec[6:5];
    assign bus.cs_branch_op = gate ? dec[4:3] : 2'b00;
    assign bus.cs_bus_read = dec[2] && gate;
    assign bus.cs_bus_write = dec[1] && gate;
    assign bus.cs_end_isr = dec[0] && gate && in_isr_q;
    assign bus.stall = stall_c && !reset;
    assign bus.isr_enter = state == IRQ_ENTRY && !reset;
    assign bus.in_isr = in_isr_q;
    assign bus.bus_error = timeout && !reset;
    assign bus.illegal = bus.instr_valid && (!known || (bus.opcode == OP_RETI && !in_isr_q));
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised multi-cycle control unit. Decodes the 7-bit RV32 opcode into datapath control signals. Also sequences stalls for data-bus accesses of configurable latency, interrupt entry, and ISR return. Sits between the instruction register and the datapath; `stall` freezes the PC and the instruction register.

Parameters:
LOAD_WAIT, 1, stall cycles per load when HANDSHAKE=0 (0..15)
STORE_WAIT, 0, stall cycles per store when HANDSHAKE=0 (0..15)
HANDSHAKE, 0, 1 = memory wait ends on bus_ready instead of a fixed count
TIMEOUT, 15, maximum wait cycles in handshake mode before bus_error (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  7  current instruction opcode
instr_valid  in  1  instruction register holds a valid instruction
bus_ready  in  1  data bus access complete (used only when HANDSHAKE=1)
irq  in  1  level-sensitive interrupt request
cs_imm_src  out  3  immediate format select
cs_reg_write  out  1  register file write enable
cs_reg_1_zero  out  1  force rs1 to x0
cs_alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
cs_alu_control  out  2  ALU-control mode
cs_mem_to_reg  out  2  write-back select
cs_branch_op  out  2  branch operation
cs_bus_read  out  1  data bus read
cs_bus_write  out  1  data bus write
cs_end_isr  out  1  return from ISR
stall  out  1  hold PC and instruction register this cycle
isr_enter  out  1  one-cycle pulse: vector to ISR
in_isr  out  1  ISR currently executing
illegal  out  1  undecodable opcode, or RETI outside ISR
bus_error  out  1  one-cycle pulse: handshake timeout

Behaviour:
- Decode is combinational from opcode. Field order: ImmSrc RegWrite Reg1Zero ALUSrc ALUCtl MemToReg BranchOp BusRead BusWrite EndISR.
  - 0110011 ArithR: 000 1 0 0 11 00 00 0 0 0
  - 0010011 ArithI: 001 1 0 1 10 00 00 0 0 0
  - 1100011 Branch: 011 0 0 0 01 00 01 0 0 0
  - 1101111 JAL: 100 1 1 1 00 10 10 0 0 0
  - 1100111 JALR: 001 1 0 1 00 10 11 0 0 0
  - 0000011 LOAD: 001 1 0 1 00 01 00 1 0 0
  - 0100011 STORE: 010 0 0 1 00 00 00 0 1 0
  - 0110111 LUI: 000 1 1 1 00 00 00 0 0 0
  - 1111111 RETI: 000 0 0 0 00 00 00 0 0 1
  - Any other opcode: all zero; illegal=1 when instr_valid=1.
- Gating: reg_write, branch_op, bus_read, bus_write and end_isr are forced to 0 when reset=1, instr_valid=0, or state=IRQ_ENTRY. imm_src, alu_* and mem_to_reg are never gated.
- FSM states: RUN, MEM_WAIT, IRQ_ENTRY. Reset state is RUN with: wait counter 0, in_isr 0, isr_enter 0, bus_error 0, stall 0. Reset during MEM_WAIT aborts the access.
- Fixed latency (HANDSHAKE=0), N = LOAD_WAIT or STORE_WAIT:
  - A valid load/store in RUN with N>0 asserts stall combinationally, loads the counter with N, and moves to MEM_WAIT.
  - In MEM_WAIT the counter decrements each cycle; stall=1 while the counter is >1.
  - Total: stall high exactly N cycles; the instruction is presented for N+1 cycles.
  - bus_read/bus_write are held for all N+1 cycles. Load reg_write is asserted only in the final, unstalled cycle.
  - N=0: no stall, single-cycle completion.
- Handshake (HANDSHAKE=1):
  - stall = !bus_ready during a load/store. Completion occurs in the cycle bus_ready=1; bus_ready=1 in the first cycle means no stall.
  - Wait cycles are counted. After TIMEOUT stalled cycles without ready: bus_error pulses, the instruction completes with reg_write suppressed, and the FSM returns to RUN.
- Interrupts:
  - irq is taken at an instruction boundary: state RUN, stall=0, in_isr=0, instr_valid=1.
  - The current instruction completes normally. The next cycle is IRQ_ENTRY: isr_enter=1, stall=1, side effects gated. in_isr is set at the end of that cycle; the FSM returns to RUN.
  - irq is ignored while in_isr=1 (no nesting) and while stalled (taken after the memory access completes).
  - RETI with in_isr=1: end_isr=1, in_isr clears next edge. irq still high is then eligible at the following boundary.
  - RETI with in_isr=0: end_isr gated to 0, illegal=1.

Test Plan:
1. Reset held 3 cycles with opcode=0110011 and instr_valid=1 -> reg_write=0, stall=0, in_isr=0. After release: reg_write=1, alu_control=11.
2. LOAD_WAIT=3, valid LOAD -> stall=1,1,1,0; bus_read high 4 cycles; reg_write=1 only in cycle 4. A following ADD is not stalled.
3. HANDSHAKE=1, TIMEOUT=4, STORE with bus_ready=0 -> stall for 4 cycles, bus_error pulses once, FSM returns to RUN. Repeat with bus_ready=1 on cycle 2 -> exactly 1 stall cycle, no error.
4. irq rises during a stalled LOAD -> load completes first, then IRQ_ENTRY: isr_enter=1 and stall=1 for one cycle, then in_isr=1. A second irq while in_isr=1 is ignored.
5. RETI inside ISR -> end_isr=1, in_isr=0 next cycle. RETI outside ISR -> end_isr=0, illegal=1.
6. opcode=0001111 valid -> illegal=1, all side-effect outputs 0. Same opcode with instr_valid=0 -> illegal=0.
